cla_pipe_addsub: RTL and testbench

Pipelined, parametrised carry-look-ahead adder/subtractor: the operand word is split into CLA blocks of `BLOCK_WIDTH` bits, one block resolved per pipeline stage, with the block carry registered between stages. It accepts one operation per cycle behind a valid/ready handshake and returns sum/difference, carry-out and signed overflow. It sits in the datapath wherever the combinational full-width adder no longer closes timing.

---
 rtl/cla_pipe_addsub.sv | 150 +++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-look-ahead adder/subtractor.
// The operand word is split into NUM_BLOCKS = DATA_WIDTH/BLOCK_WIDTH blocks. Stage k resolves
// block k with in-block look-ahead and registers the block carry for stage k+1. Upper operand
// blocks travel alongside; finished lower result blocks are carried forward. The whole pipe
// advances together whenever the output register is free or being drained.
// Optional feature: define CLA_PIPE_SAT_EN to saturate o_data on signed overflow.
module cla_pipe_addsub #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_one,
  input  logic [DATA_WIDTH-1:0] i_data_two,
  input  logic                  i_sub,
  input  logic                  i_carry,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_carry,
  output logic                  o_overflow
);

  localparam int unsigned NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

  // Per-stage registers; stage NUM_BLOCKS-1 is the output register.
  logic [NUM_BLOCKS-1:0] vld_q, vld_d;
  logic [NUM_BLOCKS-1:0] cy_q, cy_d;
  logic [DATA_WIDTH-1:0] a_q [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] b_q [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] r_q [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] a_d [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] b_d [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] r_d [NUM_BLOCKS];
  logic                  ov_q, ov_d;

  // Stage inputs: stage 0 sees the port operands, later stages see the previous register.
  logic [NUM_BLOCKS-1:0] vld_src, cy_src;
  logic [DATA_WIDTH-1:0] a_src [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] b_src [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] r_src [NUM_BLOCKS];

  logic en;

  // Global advance: the pipe moves whenever the output slot is empty or being taken.
  assign en      = i_ready | ~o_valid;
  assign o_ready = en;

  assign o_valid    = vld_q[NUM_BLOCKS-1];
  assign o_data     = r_q[NUM_BLOCKS-1];
  assign o_carry    = cy_q[NUM_BLOCKS-1];
  assign o_overflow = ov_q;

  // Operand words in the final register are not needed downstream.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[NUM_BLOCKS-1], b_q[NUM_BLOCKS-1]};

  // Route stage inputs; subtraction is folded in as A + ~B + ~borrow.
  always_comb begin
    vld_src[0] = i_valid;
    cy_src[0]  = i_sub ^ i_carry;
    a_src[0]   = i_data_one;
    b_src[0]   = i_sub ? ~i_data_two : i_data_two;
    r_src[0]   = '0;
    for (int k = 1; k < int'(NUM_BLOCKS); k++) begin
      vld_src[k] = vld_q[k-1];
      cy_src[k]  = cy_q[k-1];
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      r_src[k]   = r_q[k-1];
    end
  end

  // Resolve block k in stage k with flattened generate/propagate look-ahead.
  always_comb begin
    logic [BLOCK_WIDTH-1:0] blk_a, blk_b, gen, prop;
    logic [BLOCK_WIDTH:0]   cy;
    logic [DATA_WIDTH-1:0]  res;
    logic                   pp;
    vld_d = '0;
    cy_d  = '0;
    ov_d  = 1'b0;
    blk_a = '0;
    blk_b = '0;
    gen   = '0;
    prop  = '0;
    cy    = '0;
    res   = '0;
    pp    = 1'b0;
    for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
      blk_a = a_src[k][k*BLOCK_WIDTH +: BLOCK_WIDTH];
      blk_b = b_src[k][k*BLOCK_WIDTH +: BLOCK_WIDTH];
      gen   = blk_a & blk_b;
      prop  = blk_a ^ blk_b;
      cy[0] = cy_src[k];
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, each term independent of ripple.
      for (int i = 0; i < int'(BLOCK_WIDTH); i++) begin
        cy[i+1] = gen[i];
        pp      = prop[i];
        for (int j = i - 1; j >= 0; j--) begin
          cy[i+1] = cy[i+1] | (pp & gen[j]);
          pp      = pp & prop[j];
        end
        cy[i+1] = cy[i+1] | (pp & cy_src[k]);
      end
      res = r_src[k];
      res[k*BLOCK_WIDTH +: BLOCK_WIDTH] = prop ^ cy[BLOCK_WIDTH-1:0];
      vld_d[k] = vld_src[k];
      cy_d[k]  = cy[BLOCK_WIDTH];
      a_d[k]   = a_src[k];
      b_d[k]   = b_src[k];
      if (k == int'(NUM_BLOCKS) - 1) begin
        ov_d = cy[BLOCK_WIDTH] ^ cy[BLOCK_WIDTH-1];
`ifdef CLA_PIPE_SAT_EN
        // Overflow sign follows operand A's sign (both effective operands share it).
        if (ov_d) begin
          res = {a_src[k][DATA_WIDTH-1], {(DATA_WIDTH-1){~a_src[k][DATA_WIDTH-1]}}};
        end
`endif
      end
      r_d[k] = res;
    end
  end

  // Pipeline registers: cleared on reset, frozen as a whole while en is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ov_q  <= 1'b0;
      for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ov_q  <= ov_d;
      for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub (32-bit, 8-bit blocks, latency 4). Scoreboard built from a signed
// integer model; directed vectors pin the model to hand-computed results.
module tb_cla_pipe_addsub;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam longint SMAX = (longint'(1) << 31) - 1;
  localparam longint SMIN = -(longint'(1) << 31);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data_one = '0;
  logic [DW-1:0] i_data_two = '0;
  logic          i_sub = 1'b0;
  logic          i_carry = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_carry;
  logic          o_overflow;

  cla_pipe_addsub #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_one (i_data_one),
    .i_data_two (i_data_two),
    .i_sub      (i_sub),
    .i_carry    (i_carry),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          carry;
    logic          ov;
    int            in_cyc;
    int            stalls;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          cin;
    logic [DW-1:0] data;
    logic          carry;
    logic          ov;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   first_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result as plain integer arithmetic: unsigned sum for carry, signed sum for overflow.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic sub, input logic cin);
    exp_t          m;
    logic [DW-1:0] beff;
    logic          ci;
    logic [DW:0]   u;
    longint        s;
    beff = sub ? ~b : b;
    ci   = sub ? ~cin : cin;
    u    = {1'b0, a} + {1'b0, beff} + {{DW{1'b0}}, ci};
    s    = longint'($signed(a)) + longint'($signed(beff)) + longint'(ci);
    m.data   = u[DW-1:0];
    m.carry  = u[DW];
    m.ov     = (s > SMAX) || (s < SMIN);
`ifdef CLA_PIPE_SAT_EN
    if (s > SMAX) m.data = 32'h7FFF_FFFF;
    else if (s < SMIN) m.data = 32'h8000_0000;
`endif
    m.in_cyc = 0;
    m.stalls = 0;
    return m;
  endfunction

  // Scoreboard: sampled mid-cycle, between the driver's update and the next rising edge.
  always @(negedge i_clk) begin : mon
    exp_t e;
    cyc++;
    if (!i_rst_n) begin
      q.delete();
      first_seen = 1'b0;
    end else begin
      chk("o_ready_rule", {63'd0, o_ready}, {63'd0, i_ready | ~o_valid});
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_o_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          e = q[0];
          chk("o_data", {32'd0, o_data}, {32'd0, e.data});
          chk("o_carry", {63'd0, o_carry}, {63'd0, e.carry});
          chk("o_overflow", {63'd0, o_overflow}, {63'd0, e.ov});
          if (!first_seen) begin
            chk("latency", 64'(cyc), 64'(e.in_cyc + NB + (stalls - e.stalls)));
          end
          first_seen = 1'b1;
          if (i_ready) begin
            void'(q.pop_front());
            first_seen = 1'b0;
          end
        end
      end
      if (i_valid && o_ready) begin
        e = model(i_data_one, i_data_two, i_sub, i_carry);
        e.in_cyc = cyc;
        e.stalls = stalls;
        q.push_back(e);
      end
      if (!o_ready) stalls++;
    end
  end

  // Present one op and hold it until accepted; optionally randomise i_ready each cycle.
  task automatic send_op(input logic [DW-1:0] a_v, input logic [DW-1:0] b_v,
                         input logic sub_v, input logic cin_v, input bit rand_rdy);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    i_data_one = a_v;
    i_data_two = b_v;
    i_sub      = sub_v;
    i_carry    = cin_v;
    i_valid    = 1'b1;
    while (!done) begin
      if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
      #1;
      done = o_ready;
      @(posedge i_clk);
      #1;
      n++;
      if (!done && n > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    exp_t m;
    int   w;
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef CLA_PIPE_SAT_EN
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`endif
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vecs[5] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_o_data", {32'd0, o_data}, 64'd0);
    chk("rst_o_carry", {63'd0, o_carry}, 64'd0);
    chk("rst_o_overflow", {63'd0, o_overflow}, 64'd0);
    chk("rst_o_ready", {63'd0, o_ready}, 64'd1);
    i_rst_n = 1'b1;

    // Pin the model to hand-computed results.
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      chk($sformatf("model_data[%0d]", i), {32'd0, m.data}, {32'd0, vecs[i].data});
      chk($sformatf("model_carry[%0d]", i), {63'd0, m.carry}, {63'd0, vecs[i].carry});
      chk($sformatf("model_ov[%0d]", i), {63'd0, m.ov}, {63'd0, vecs[i].ov});
    end

    // Directed vectors back to back.
    idle(1);
    foreach (vecs[i]) send_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0);
    idle(8);

    // Bubbles: alternate valid cycles, output pattern must trail by NB cycles.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send_op(32'h1111_0000 * 32'(i + 1), 32'h00F0_0F0F, 1'b0, 1'b1, 1'b0);
      else idle(1);
    end
    idle(8);

    // Streaming with random back-pressure.
    for (int i = 0; i < 16; i++) begin
      send_op($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    i_ready = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      idle(1);
      w++;
    end
    chk("stream_drain", 64'(q.size()), 64'd0);

    // Reset mid-stream: one result held at the output, three more in flight.
    send_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    send_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send_op(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    i_ready = 1'b0;
    send_op(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_o_valid", {63'd0, o_valid}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_o_data", {32'd0, o_data}, 64'd0);
    chk("midrst_o_carry", {63'd0, o_carry}, 64'd0);
    chk("midrst_o_overflow", {63'd0, o_overflow}, 64'd0);
    chk("midrst_o_ready", {63'd0, o_ready}, 64'd1);
    idle(2);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    idle(10);

    // One last op after reset to confirm the pipe still works.
    send_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (q.size() != 0 && w < 20) begin
      idle(1);
      w++;
    end
    chk("final_drain", 64'(q.size()), 64'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
